seq_divider: RTL and testbench

//  Parametrised multi-cycle integer divider for the CPU execute stage; successor to the 16-bit unsigned divider.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 26 ++
 rtl/seq_divider.sv | 172 +++++++++++++++++
 tb/tb_seq_divider.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types for the sequential divider: FSM state encoding and a result record.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_W_MAX = 64;

    typedef struct packed {
        logic [DIV_W_MAX-1:0] q;
        logic [DIV_W_MAX-1:0] r;
        logic                 exception;
    } div_result_t;

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring step: shift next dividend bit into the
// partial remainder, trial-subtract the divisor, and shift the quotient bit in.
module div_step #(
    parameter int N = 16
) (
    input  logic [N-1:0] rem_in,
    input  logic [N-1:0] dvd_in,
    input  logic [N-1:0] dsr,
    output logic [N-1:0] rem_out,
    output logic [N-1:0] dvd_out,
    output logic         qbit
);

    logic [N:0]   rem_sh;
    logic [N-1:0] diff;

    always_comb begin
        rem_sh  = {rem_in, dvd_in[N-1]};
        qbit    = (rem_sh >= {1'b0, dsr});
        // When the subtract is taken the result is below dsr, so N bits hold it exactly.
        diff    = rem_sh[N-1:0] - dsr;
        rem_out = qbit ? diff : rem_sh[N-1:0];
        dvd_out = {dvd_in[N-2:0], qbit};
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider with quotient, remainder and divide-by-zero flag.
// Optional signed operation is compiled in when DIV_SIGNED_EN is defined.
module seq_divider
    import div_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic         signed_mode,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         ready,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         exception
);

    localparam int CNT_W = $clog2(N) + 1;

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     dvd_q, dvd_d;
    logic [N-1:0]     dsr_q, dsr_d;
    logic [N-1:0]     rem_q, rem_d;
    logic [N-1:0]     quo_q, quo_d;
    logic [N-1:0]     res_r_q, res_r_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             exc_q, exc_d;
    logic             zero_q, zero_d;

    logic [N-1:0]     step_rem;
    logic [N-1:0]     step_dvd;
    logic             step_qbit_unused;

    logic             a_neg;
    logic             b_neg;

`ifdef DIV_SIGNED_EN
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    assign a_neg = signed_mode & dividend[N-1];
    assign b_neg = signed_mode & divisor[N-1];
`else
    logic             signed_mode_unused;

    assign signed_mode_unused = signed_mode;
    assign a_neg = 1'b0;
    assign b_neg = 1'b0;
`endif

    div_step #(.N(N)) u_step (
        .rem_in  (rem_q),
        .dvd_in  (dvd_q),
        .dsr     (dsr_q),
        .rem_out (step_rem),
        .dvd_out (step_dvd),
        .qbit    (step_qbit_unused)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        res_r_d = res_r_q;
        busy_d  = busy_q;
        ready_d = 1'b0;
        exc_d   = exc_q;
        zero_d  = zero_q;
`ifdef DIV_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (req) begin
                    busy_d = 1'b1;
                    exc_d  = 1'b0;
                    rem_d  = '0;
                    cnt_d  = CNT_W'(N - 1);
                    dsr_d  = b_neg ? -divisor : divisor;
                    zero_d = (divisor == '0);
`ifdef DIV_SIGNED_EN
                    qneg_d = a_neg ^ b_neg;
                    rneg_d = a_neg;
`endif
                    if (divisor == '0) begin
                        // Raw dividend is kept so it can be returned untouched as R.
                        dvd_d   = dividend;
                        state_d = DONE;
                    end else begin
                        dvd_d   = a_neg ? -dividend : dividend;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = step_dvd;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                ready_d = 1'b1;
                exc_d   = zero_q;
                state_d = IDLE;
                if (zero_q) begin
                    quo_d   = '1;
                    res_r_d = dvd_q;
                end else begin
`ifdef DIV_SIGNED_EN
                    quo_d   = qneg_q ? -dvd_q : dvd_q;
                    res_r_d = rneg_q ? -rem_q : rem_q;
`else
                    quo_d   = dvd_q;
                    res_r_d = rem_q;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            exc_q   <= 1'b0;
            quo_q   <= '0;
            res_r_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            exc_q   <= exc_d;
            quo_q   <= quo_d;
            res_r_q <= res_r_d;
        end
        dvd_q  <= dvd_d;
        dsr_q  <= dsr_d;
        rem_q  <= rem_d;
        zero_q <= zero_d;
`ifdef DIV_SIGNED_EN
        qneg_q <= qneg_d;
        rneg_q <= rneg_d;
`endif
    end

    assign busy      = busy_q;
    assign ready     = ready_q;
    assign Q         = quo_q;
    assign R         = res_r_q;
    assign exception = exc_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, randomized ops against an
// arithmetic reference, back-to-back handshake and mid-operation reset sequences.
module tb_seq_divider;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic         signed_mode;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         ready;
    logic [N-1:0] Q;
    logic [N-1:0] R;
    logic         exception;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .ready       (ready),
        .Q           (Q),
        .R           (R),
        .exception   (exception)
    );

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         sm;
        logic [N-1:0] exp_q;
        logic [N-1:0] exp_r;
        logic         exp_exc;
        int           exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference result computed directly from the arithmetic definition.
    task automatic ref_div(input logic [N-1:0] a, input logic [N-1:0] b, input logic sm,
                           output logic [N-1:0] q, output logic [N-1:0] r,
                           output logic exc, output int lat);
        int sa, sb, sq, sr;
        logic use_signed;
`ifdef DIV_SIGNED_EN
        use_signed = sm;
`else
        use_signed = 1'b0;
`endif
        if (b == 0) begin
            q = '1; r = a; exc = 1'b1; lat = 1;
        end else begin
            exc = 1'b0; lat = N + 1;
            if (use_signed) begin
                sa = int'($signed(a));
                sb = int'($signed(b));
                sq = sa / sb;
                sr = sa % sb;
                q  = sq[N-1:0];
                r  = sr[N-1:0];
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endtask

    // Issue one request, measure edges until ready, check results and the end of the pulse.
    task automatic do_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic sm, input logic [N-1:0] eq, input logic [N-1:0] er,
                         input logic eexc, input int elat);
        int lat;
        @(negedge clk);
        req = 1'b1; dividend = a; divisor = b; signed_mode = sm;
        @(posedge clk);
        #1;
        req = 1'b0; dividend = $urandom; divisor = $urandom;
        chk({tag, " busy_after_accept"}, busy, 1);
        lat = 0;
        while (!ready && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, lat, elat);
        chk({tag, " Q"}, Q, eq);
        chk({tag, " R"}, R, er);
        chk({tag, " exception"}, exception, eexc);
        @(posedge clk);
        #1;
        chk({tag, " ready_pulse_end"}, ready, 0);
        chk({tag, " busy_end"}, busy, 0);
    endtask

    initial begin
        logic [N-1:0] mq, mr, a, b;
        logic mexc, sm;
        int mlat, lat;

        rst = 1'b1; req = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset ready", ready, 0);
        chk("reset exception", exception, 0);
        chk("reset Q", Q, 0);
        chk("reset R", R, 0);
        @(negedge clk);
        rst = 1'b0;

        vecs.push_back('{16'd100,   16'd7,      1'b0, 16'd14,     16'd2,      1'b0, 17});
        vecs.push_back('{16'd1234,  16'd0,      1'b0, 16'hFFFF,   16'd1234,   1'b1, 1});
        vecs.push_back('{16'd5,     16'd9,      1'b0, 16'd0,      16'd5,      1'b0, 17});
        vecs.push_back('{16'd65535, 16'd1,      1'b0, 16'd65535,  16'd0,      1'b0, 17});
        vecs.push_back('{16'd65535, 16'd65535,  1'b0, 16'd1,      16'd0,      1'b0, 17});
        vecs.push_back('{16'd0,     16'd3,      1'b0, 16'd0,      16'd0,      1'b0, 17});
        vecs.push_back('{16'h8000,  16'hFFFF,   1'b0, 16'd0,      16'h8000,   1'b0, 17});
        vecs.push_back('{16'd50000, 16'd256,    1'b0, 16'd195,    16'd80,     1'b0, 17});
`ifdef DIV_SIGNED_EN
        vecs.push_back('{16'hFFF9,  16'd2,      1'b1, 16'hFFFD,   16'hFFFF,   1'b0, 17});
        vecs.push_back('{16'd7,     16'hFFFE,   1'b1, 16'hFFFD,   16'd1,      1'b0, 17});
        vecs.push_back('{16'h8000,  16'hFFFF,   1'b1, 16'h8000,   16'd0,      1'b0, 17});
        vecs.push_back('{16'hFFF9,  16'd0,      1'b1, 16'hFFFF,   16'hFFF9,   1'b1, 1});
`else
        vecs.push_back('{16'hFFF9,  16'd2,      1'b1, 16'h7FFC,   16'd1,      1'b0, 17});
        vecs.push_back('{16'd7,     16'hFFFE,   1'b1, 16'd0,      16'd7,      1'b0, 17});
        vecs.push_back('{16'h8000,  16'hFFFF,   1'b1, 16'd0,      16'h8000,   1'b0, 17});
`endif

        foreach (vecs[i]) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sm,
                  vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_exc, vecs[i].exp_lat);
        end

        for (int i = 0; i < 40; i++) begin
            a  = N'($urandom);
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = N'($urandom_range(1, 15));
                2:       b = N'($urandom_range(16'hFFF0, 16'hFFFF));
                default: b = N'($urandom);
            endcase
            sm = 1'($urandom);
            ref_div(a, b, sm, mq, mr, mexc, mlat);
            do_op($sformatf("rand%0d", i), a, b, sm, mq, mr, mexc, mlat);
        end

        // Back-to-back: req held high throughout; the second operands appear mid-operation.
        @(negedge clk);
        req = 1'b1; signed_mode = 1'b0; dividend = 16'd5; divisor = 16'd9;
        @(posedge clk);
        #1;
        dividend = 16'd65535; divisor = 16'd1;
        lat = 0;
        while (!ready && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("b2b first latency", lat, 17);
        chk("b2b first Q", Q, 0);
        chk("b2b first R", R, 5);
        chk("b2b busy during ready", busy, 1);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ready && lat < 40);
        req = 1'b0;
        chk("b2b ready spacing", lat, 18);
        chk("b2b second Q", Q, 16'd65535);
        chk("b2b second R", R, 0);
        @(posedge clk);
        #1;
        chk("b2b idle busy", busy, 0);

        // Reset five cycles into a calculation: abort with no ready pulse.
        @(negedge clk);
        req = 1'b1; dividend = 16'd100; divisor = 16'd7;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort ready", ready, 0);
        chk("abort Q", Q, 0);
        chk("abort R", R, 0);
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (ready) lat++;
        end
        chk("abort no ready pulse", lat, 0);
        do_op("after_abort", 16'd1000, 16'd33, 1'b0, 16'd30, 16'd10, 1'b0, 17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
